// File: rtl/led_frame_rx.sv
// Serial LED frame receiver: synchronizes the host sck/sdi/load link into clk,
// length-checks each frame and double-buffers the committed x/y images.
module led_frame_rx #(
   parameter int SYNC_STAGES = 2,
   parameter int FRAME_BITS  = 144
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        sck,
   input  logic        sdi,
   input  logic        load,
   output logic [71:0] xMatrix,
   output logic [71:0] yMatrix,
   output logic        core_load,
   output logic        frame_valid,
   output logic        frame_strobe,
   output logic        frame_err
);

   localparam logic [7:0] FRAME_CNT = 8'(FRAME_BITS);

   typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

   state_t state, state_nx;

   logic [SYNC_STAGES-1:0] sck_sync, sdi_sync, load_sync;
   logic                   sck_s, sdi_s, load_s;
   logic                   sck_d, load_d;
   logic                   sck_rise, load_rise, load_fall;
   logic [FRAME_BITS-1:0]  shadow;
   logic [7:0]             count;

   // sdi shares sck's synchronizer depth so sdi_s is aligned with sck_rise
   always_ff @(posedge clk) begin
      if (reset) begin
         sck_sync  <= '0;
         sdi_sync  <= '0;
         load_sync <= '0;
         sck_d     <= 1'b0;
         load_d    <= 1'b0;
      end else begin
         sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
         sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], sdi};
         load_sync <= {load_sync[SYNC_STAGES-2:0], load};
         sck_d     <= sck_s;
         load_d    <= load_s;
      end
   end

   assign sck_s     = sck_sync[SYNC_STAGES-1];
   assign sdi_s     = sdi_sync[SYNC_STAGES-1];
   assign load_s    = load_sync[SYNC_STAGES-1];
   assign sck_rise  = sck_s & ~sck_d;
   assign load_rise = load_s & ~load_d;
   assign load_fall = ~load_s & load_d;

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (load_rise) state_nx = RECV;
         RECV:    if (load_fall) state_nx = CHECK;
         CHECK:   state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         count        <= '0;
         shadow       <= '0;
         xMatrix      <= '0;
         yMatrix      <= '0;
         core_load    <= 1'b0;
         frame_valid  <= 1'b0;
         frame_strobe <= 1'b0;
         frame_err    <= 1'b0;
      end else begin
         state        <= state_nx;
         core_load    <= (state_nx != IDLE);
         frame_strobe <= 1'b0;
         frame_err    <= 1'b0;
         case (state)
            IDLE: if (load_rise) count <= '0;
            RECV: if (sck_rise) begin
               // a bit arriving with load_fall is still counted before CHECK
               shadow <= {shadow[FRAME_BITS-2:0], sdi_s};
               if (count != 8'hFF) count <= count + 8'd1;
            end
            CHECK: begin
               if (count == FRAME_CNT) begin
                  xMatrix      <= shadow[FRAME_BITS-1 -: 72];
                  yMatrix      <= shadow[71:0];
                  frame_strobe <= 1'b1;
                  frame_valid  <= 1'b1;
               end else begin
                  frame_err <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_led_frame_rx.sv
// Randomized directed bench for led_frame_rx against a frame-level reference model.
module tb_led_frame_rx;

   localparam int H = 2;

   logic        clk = 1'b0;
   logic        reset, sck, sdi, load;
   logic [71:0] xMatrix, yMatrix;
   logic        core_load, frame_valid, frame_strobe, frame_err;

   int checks = 0;
   int errors = 0;
   int err_pulses = 0;
   logic [143:0] commits[$];
   logic [143:0] cur, f, prev;
   int           nc, ne;
   logic         lastb;

   led_frame_rx #(.SYNC_STAGES(2), .FRAME_BITS(144)) dut (
      .clk(clk), .reset(reset), .sck(sck), .sdi(sdi), .load(load),
      .xMatrix(xMatrix), .yMatrix(yMatrix), .core_load(core_load),
      .frame_valid(frame_valid), .frame_strobe(frame_strobe), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (frame_strobe) commits.push_back({xMatrix, yMatrix});
      if (frame_err) err_pulses++;
   end

   task automatic check(input string tag, input logic [143:0] obs, input logic [143:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [143:0] rand_frame();
      logic [143:0] v;
      for (int i = 0; i < 144; i += 32) v = {v[111:0], $urandom()};
      return v;
   endfunction

   task automatic clk_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bit(input logic b);
      sdi = b; clk_n(H);
      sck = 1'b1; clk_n(H);
      sck = 1'b0;
   endtask

   // first bit sent is bit 143 of the frame vector (xMatrix[71])
   task automatic send_frame_bits(input logic [143:0] v, input int n);
      for (int i = 0; i < n; i++) send_bit(v[143 - (i % 144)]);
   endtask

   task automatic start_frame();
      load = 1'b1; clk_n(3);
   endtask

   task automatic end_frame();
      clk_n(H); load = 1'b0; clk_n(8);
   endtask

   initial begin
      reset = 1'b1; sck = 1'b0; sdi = 1'b0; load = 1'b0;
      clk_n(4);
      reset = 1'b0; clk_n(2);
      check("rst_x", 144'(xMatrix), 144'd0);
      check("rst_y", 144'(yMatrix), 144'd0);
      check("rst_flags", 144'({core_load, frame_valid, frame_strobe, frame_err}), 144'd0);

      // 1: good frame with fixed x pattern, plus commit latency
      f = {72'hFF_0102040810204080, 72'h0};
      start_frame();
      check("core_load_recv", 144'(core_load), 144'd1);
      send_frame_bits(f, 144);
      clk_n(H);
      load = 1'b0;
      repeat (3) @(posedge clk);
      #1 check("strobe_early", 144'(frame_strobe), 144'd0);
      check("core_load_check", 144'(core_load), 144'd1);
      @(posedge clk);
      #1 check("strobe_latency", 144'(frame_strobe), 144'd1);
      check("core_load_done", 144'(core_load), 144'd0);
      clk_n(6);
      check("f1_ncommit", 144'(commits.size()), 144'd1);
      check("f1_data", {xMatrix, yMatrix}, f);
      check("f1_cols", 144'(xMatrix[71:64]), 144'hFF);
      check("f1_valid", 144'(frame_valid), 144'd1);
      prev = f;

      // 2: short / long / saturated frames are rejected, image kept
      for (int t = 0; t < 3; t++) begin
         int n;
         n = (t == 0) ? 143 : (t == 1) ? 145 : 300;
         nc = commits.size(); ne = err_pulses;
         start_frame();
         send_frame_bits(rand_frame(), n);
         end_frame();
         check($sformatf("bad%0d_err", n), 144'(err_pulses - ne), 144'd1);
         check($sformatf("bad%0d_nocommit", n), 144'(commits.size() - nc), 144'd0);
         check($sformatf("bad%0d_keep", n), {xMatrix, yMatrix}, prev);
         check($sformatf("bad%0d_valid", n), 144'(frame_valid), 144'd1);
      end

      // 3: last sck rise coincides with load falling
      f = rand_frame();
      nc = commits.size(); ne = err_pulses;
      start_frame();
      send_frame_bits(f, 143);
      lastb = f[0];
      sdi = lastb; clk_n(H);
      sck = 1'b1; load = 1'b0; clk_n(H);
      sck = 1'b0; clk_n(8);
      check("same_ncommit", 144'(commits.size() - nc), 144'd1);
      check("same_noerr", 144'(err_pulses - ne), 144'd0);
      check("same_data", {xMatrix, yMatrix}, f);
      check("same_y0", 144'(yMatrix[0]), 144'(lastb));
      prev = f;

      // 4: reset mid-frame with load held high, then a full resend
      start_frame();
      send_frame_bits(rand_frame(), 70);
      reset = 1'b1; clk_n(3);
      check("mid_rst_xy", {xMatrix, yMatrix}, 144'd0);
      check("mid_rst_flags", 144'({core_load, frame_valid, frame_strobe, frame_err}), 144'd0);
      reset = 1'b0;
      f = rand_frame();
      nc = commits.size(); ne = err_pulses;
      clk_n(3);
      check("mid_rst_restart", 144'(core_load), 144'd1);
      send_frame_bits(f, 144);
      end_frame();
      check("mid_ncommit", 144'(commits.size() - nc), 144'd1);
      check("mid_noerr", 144'(err_pulses - ne), 144'd0);
      check("mid_data", {xMatrix, yMatrix}, f);

      // 5: back-to-back frames with minimum load-low gap
      begin
         logic [143:0] fa, fb;
         fa = rand_frame(); fb = rand_frame();
         nc = commits.size(); ne = err_pulses;
         start_frame();
         send_frame_bits(fa, 144);
         clk_n(H); load = 1'b0; clk_n(2);
         start_frame();
         send_frame_bits(fb, 144);
         end_frame();
         check("b2b_ncommit", 144'(commits.size() - nc), 144'd2);
         check("b2b_noerr", 144'(err_pulses - ne), 144'd0);
         if (commits.size() - nc == 2) begin
            check("b2b_first", commits[nc], fa);
            check("b2b_second", commits[nc+1], fb);
         end
         check("b2b_final", {xMatrix, yMatrix}, fb);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
